// File: rtl/eks_phase_sched.sv
// Phase scheduler for the bcrypt EksBlowfish core: walks one hash job through
// SETUP, 2^cost key/salt expansion pairs and the ctext encryption passes.
module eks_phase_sched #(
    parameter int unsigned COST_W    = 5,
    parameter int unsigned MIN_COST  = 4,
    parameter int unsigned MAX_COST  = 31,
    parameter int unsigned ENC_ITERS = 64
) (
    input  logic              clk_3,
    input  logic              rst_l,
    input  logic              req_i,
    input  logic [COST_W-1:0] cost_i,
    input  logic              abort_i,
    input  logic              phase_done_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              phase_go_o,
    output logic [2:0]        phase_sel_o,
    output logic [31:0]       rounds_left_o,
    output logic [6:0]        enc_left_o,
    output logic              done_o,
    output logic              cost_err_o
);

    localparam int unsigned RND_W = 32;
    localparam int unsigned ENC_W = 7;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_NONE     = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_SETUP    = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_EXP_KEY  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_EXP_SALT = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_ENC      = SEL_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EXP_KEY,
        S_EXP_SALT,
        S_ENC,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               wait_q, wait_d;
    logic [RND_W-1:0]   rounds_q, rounds_d;
    logic [ENC_W-1:0]   enc_q, enc_d;

    logic               go_q, go_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cost_err_q, cost_err_d;

    logic               cost_ok;
    logic               work_d;

    // Legality check done at 32 bits so MIN/MAX compare cleanly against any COST_W.
    assign cost_ok = (32'(cost_i) >= MIN_COST) && (32'(cost_i) <= MAX_COST);

    function automatic logic [SEL_W-1:0] sel_of(input state_e s);
        case (s)
            S_SETUP:    sel_of = SEL_SETUP;
            S_EXP_KEY:  sel_of = SEL_EXP_KEY;
            S_EXP_SALT: sel_of = SEL_EXP_SALT;
            S_ENC:      sel_of = SEL_ENC;
            default:    sel_of = SEL_NONE;
        endcase
    endfunction

    // State, counters and registered outputs.
    always_ff @(posedge clk_3 or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= S_IDLE;
            wait_q     <= 1'b0;
            rounds_q   <= '0;
            enc_q      <= '0;
            go_q       <= 1'b0;
            sel_q      <= SEL_NONE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cost_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rounds_q   <= rounds_d;
            enc_q      <= enc_d;
            go_q       <= go_d;
            sel_q      <= sel_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cost_err_q <= cost_err_d;
        end
    end

    // Next state: ISSUE (wait_q=0) lasts one cycle, WAIT holds until phase_done.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        rounds_d   = rounds_q;
        enc_d      = enc_q;
        cost_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (cost_ok) begin
                        state_d  = S_SETUP;
                        wait_d   = 1'b0;
                        rounds_d = RND_W'(1) << cost_i;
                        enc_d    = ENC_W'(ENC_ITERS);
                    end else begin
                        cost_err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                wait_d  = 1'b0;
            end
            default: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (phase_done_i) begin
                    wait_d = 1'b0;
                    case (state_q)
                        S_SETUP:    state_d = S_EXP_KEY;
                        S_EXP_KEY:  state_d = S_EXP_SALT;
                        S_EXP_SALT: begin
                            rounds_d = rounds_q - RND_W'(1);
                            state_d  = (rounds_d == '0) ? S_ENC : S_EXP_KEY;
                        end
                        S_ENC: begin
                            enc_d   = enc_q - ENC_W'(1);
                            state_d = (enc_d == '0) ? S_DONE : S_ENC;
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase

        // Abort wins over any concurrent phase_done; IDLE is unaffected.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            wait_d   = 1'b0;
            rounds_d = '0;
            enc_d    = '0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        work_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        go_d    = work_d && !wait_d;
        sel_d   = sel_of(state_d);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign ready_o       = ready_q;
    assign busy_o        = busy_q;
    assign phase_go_o    = go_q;
    assign phase_sel_o   = sel_q;
    assign rounds_left_o = rounds_q;
    assign enc_left_o    = enc_q;
    assign done_o        = done_q;
    assign cost_err_o    = cost_err_q;

endmodule

// File: tb/tb_eks_phase_sched.sv
// Directed/randomized bench for eks_phase_sched; expected phase sequence and
// counter values come from an arithmetic model of the job schedule.
module tb_eks_phase_sched;

    logic        clk_3 = 1'b0;
    logic        rst_l;
    logic        req_i;
    logic [4:0]  cost_i;
    logic        abort_i;
    logic        phase_done_i;
    logic        ready_o;
    logic        busy_o;
    logic        phase_go_o;
    logic [2:0]  phase_sel_o;
    logic [31:0] rounds_left_o;
    logic [6:0]  enc_left_o;
    logic        done_o;
    logic        cost_err_o;

    int n_total = 0;
    int n_pass  = 0;

    eks_phase_sched dut (
        .clk_3         (clk_3),
        .rst_l         (rst_l),
        .req_i         (req_i),
        .cost_i        (cost_i),
        .abort_i       (abort_i),
        .phase_done_i  (phase_done_i),
        .ready_o       (ready_o),
        .busy_o        (busy_o),
        .phase_go_o    (phase_go_o),
        .phase_sel_o   (phase_sel_o),
        .rounds_left_o (rounds_left_o),
        .enc_left_o    (enc_left_o),
        .done_o        (done_o),
        .cost_err_o    (cost_err_o)
    );

    always #5 clk_3 = ~clk_3;

    task automatic tick();
        @(negedge clk_3);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Idle signature: {ready,busy,go,sel,done,cost_err}, counters zero.
    task automatic chk_idle(input string tag);
        chk({tag, "_flags"}, 64'({ready_o, busy_o, phase_go_o, phase_sel_o, done_o, cost_err_o}),
            64'({1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}));
        chk({tag, "_rounds"}, 64'(rounds_left_o), 64'd0);
        chk({tag, "_enc"}, 64'(enc_left_o), 64'd0);
    endtask

    // Unit n of a job: 0 SETUP, then KEY/SALT pairs, then ENC passes.
    function automatic void exp_unit(input int c, input longint n, output logic [2:0] sel,
                                     output longint rnd, output int enc);
        longint p;
        p = longint'(1) << c;
        if (n == 0) begin
            sel = 3'd1; rnd = p; enc = 64;
        end else if (n <= 2 * p) begin
            sel = (n % 2 == 1) ? 3'd2 : 3'd3;
            rnd = p - (n - 1) / 2;
            enc = 64;
        end else begin
            sel = 3'd4; rnd = 0;
            enc = 64 - int'(n - 1 - 2 * p);
        end
    endfunction

    // mode 0: run to completion; 1: abort+phase_done at unit stop_n WAIT; 2: reset there.
    task automatic run_job(input int c, input int mode, input longint stop_n,
                           input bit noise, input bit abort_at_req);
        longint     total;
        logic [2:0] sel;
        longint     rnd;
        int         enc;
        int         gos;
        total = 1 + 2 * (longint'(1) << c) + 64;
        gos = 0;
        cost_i  = 5'(c);
        req_i   = 1'b1;
        abort_i = abort_at_req;
        tick();
        req_i   = 1'b0;
        abort_i = 1'b0;
        for (longint n = 0; n < total; n++) begin
            exp_unit(c, n, sel, rnd, enc);
            if (phase_go_o === 1'b1) gos++;
            chk("go", 64'(phase_go_o), 64'd1);
            chk("sel", 64'(phase_sel_o), 64'(sel));
            chk("rounds", 64'(rounds_left_o), 64'(rnd));
            chk("enc", 64'(enc_left_o), 64'(enc));
            chk("busy_rdy", 64'({busy_o, ready_o}), 64'(2'b10));
            if (noise) begin
                phase_done_i = ($urandom_range(0, 3) == 0);
                req_i  = 1'($urandom_range(0, 1));
                cost_i = 5'($urandom_range(4, 31));
            end
            tick();
            phase_done_i = 1'b0;
            chk("wait", 64'({phase_go_o, phase_sel_o}), 64'({1'b0, sel}));
            if (mode == 1 && n == stop_n) begin
                req_i = 1'b0;
                abort_i = 1'b1;
                phase_done_i = 1'b1;
                tick();
                abort_i = 1'b0;
                phase_done_i = 1'b0;
                chk_idle("abort");
                tick();
                chk("abort_nodone", 64'({done_o, phase_go_o, ready_o}), 64'(3'b001));
                return;
            end
            if (mode == 2 && n == stop_n) begin
                req_i = 1'b0;
                #2 rst_l = 1'b0;
                #1 chk_idle("async_rst");
                tick();
                rst_l = 1'b1;
                chk_idle("rst_hold");
                return;
            end
            repeat ($urandom_range(0, 2)) tick();
            chk("still_wait", 64'({phase_go_o, phase_sel_o}), 64'({1'b0, sel}));
            phase_done_i = 1'b1;
            tick();
            phase_done_i = 1'b0;
        end
        req_i = 1'b0;
        chk("go_count", 64'(gos), 64'(total));
        chk("done", 64'({done_o, busy_o, ready_o, phase_go_o, phase_sel_o}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 3'd0}));
        tick();
        chk_idle("after_done");
    endtask

    initial begin
        int big;
        rst_l = 1'b0;
        req_i = 1'b0;
        cost_i = '0;
        abort_i = 1'b0;
        phase_done_i = 1'b0;
        repeat (2) tick();
        chk_idle("reset");
        rst_l = 1'b1;
        tick();
        chk_idle("post_reset");

        // Nominal cost=4 job: 97 units.
        run_job(4, 0, 0, 1'b0, 1'b0);

        // Illegal costs rejected with one-cycle cost_err.
        cost_i = 5'd3;
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        chk("cerr3", 64'({cost_err_o, ready_o, phase_go_o}), 64'(3'b110));
        chk("cerr3_rounds", 64'(rounds_left_o), 64'd0);
        tick();
        chk_idle("cerr3_after");
        big = 32;
        cost_i = big[4:0];
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        chk("cerr0", 64'({cost_err_o, ready_o, phase_go_o}), 64'(3'b110));
        tick();
        chk_idle("cerr0_after");

        // Stray phase_done while idle.
        phase_done_i = 1'b1;
        tick();
        phase_done_i = 1'b0;
        chk_idle("idle_done");

        // cost=5 with phase_done glitches on go cycles, request noise, and abort alongside req.
        run_job(5, 0, 0, 1'b1, 1'b1);

        // cost=31 aborted in the third EXP_SALT wait, then a clean cost=4 job.
        run_job(31, 1, 6, 1'b0, 1'b0);
        run_job(4, 0, 0, 1'b0, 1'b0);

        // cost=6 with repeated req while busy.
        run_job(6, 0, 0, 1'b1, 1'b0);

        // Async reset mid-ENC at enc_left=30 (unit 1+32+34), then nominal rerun.
        run_job(4, 2, 67, 1'b0, 1'b0);
        run_job(4, 0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eks_phase_sched.md
Name: eks_phase_sched

Overview:
Phase scheduler for the bcrypt Feistel/S-box datapath. It runs on the round clock clk_3 and walks one hash job through four phases:
- EksBlowfishSetup initial expand: one SETUP phase.
- 2^cost alternating ExpandKey(key) / ExpandKey(salt) iterations.
- 64 ctext encryption passes.

It issues one phase_go per unit of work to the core, waits for the core's phase_done, and reports job completion or a rejected cost to the host-side loader.

Parameters:
COST_W, 5, width of cost input.
MIN_COST, 4, smallest legal cost.
MAX_COST, 31, largest legal cost.
ENC_ITERS, 64, ctext encryption passes per job.

Ports:
clk_3  in  1  round clock; all state on rising edge.
rst_l  in  1  async active-low reset.
req  in  1  job request; sampled only when ready=1.
cost  in  COST_W  log2 of round count; sampled with req.
abort  in  1  synchronous job cancel.
phase_done  in  1  one-cycle pulse from core: current phase unit complete.
ready  out  1  scheduler idle, accepts req.
busy  out  1  job in progress (SETUP..DONE).
phase_go  out  1  one-cycle pulse: core starts unit selected by phase_sel.
phase_sel  out  3  0 NONE, 1 SETUP, 2 EXP_KEY, 3 EXP_SALT, 4 ENC.
rounds_left  out  32  remaining key/salt iteration pairs.
enc_left  out  7  remaining encryption passes.
done  out  1  one-cycle pulse: job finished.
cost_err  out  1  one-cycle pulse: req with illegal cost rejected.

Behaviour:
Reset and idle:
- Reset (async, rst_l=0): state IDLE, ready=1, all other outputs 0, rounds_left=0, enc_left=0, wait flag=0.
- Deasserting rst_l takes effect at the next edge.

States: IDLE, SETUP, EXP_KEY, EXP_SALT, ENC, DONE. Each non-idle work state has two sub-steps:
- ISSUE: phase_go=1 for exactly one cycle.
- WAIT: phase_go=0 until phase_done.

IDLE:
- req=1 and MIN_COST<=cost<=MAX_COST: latch rounds_left=1<<cost, enc_left=ENC_ITERS, go to SETUP/ISSUE.
- First phase_go is visible in the cycle after the req edge.
- req=1 with illegal cost: cost_err=1 for one cycle, stay IDLE, counters untouched.

Work-state transitions on phase_done sampled in WAIT; the next ISSUE pulse appears in the very next cycle:
- SETUP -> EXP_KEY.
- EXP_KEY -> EXP_SALT.
- EXP_SALT: decrement rounds_left. If the new value is 0, go to ENC; else go to EXP_KEY.
- ENC: decrement enc_left. If the new value is 0, go to DONE; else ENC/ISSUE again.

DONE:
- Lasts one cycle: done=1, busy=1, ready=0.
- Next cycle: IDLE, ready=1.

Output rules:
- phase_sel is held constant for the whole phase (ISSUE and WAIT).
- phase_sel=0 in IDLE and DONE.
- busy=1 in every state except IDLE.
- ready = (state==IDLE).

Boundary conditions:
- phase_done during an ISSUE cycle, or in IDLE/DONE: ignored. No state or counter change.
- req while ready=0: ignored; no queuing.
- abort=1 in any non-IDLE state: next state IDLE. Counters clear to 0, phase_go=0, no done pulse.
- abort has priority over a simultaneous phase_done.
- abort in IDLE: no effect. req in the same cycle is still accepted.
- Counters never wrap: rounds_left reaches 0 only in the EXP_SALT->ENC transition; enc_left only in ENC->DONE.
- cost=31 loads 32'h8000_0000. The shift is computed at 32-bit width, with no overflow.

Total phase_go pulses per job: 1 + 2*2^cost + ENC_ITERS.

Test Plan:
- Reset, then cost=4 req, core answers each go with phase_done 2 cycles later -> exactly 97 phase_go pulses. phase_sel sequence: 1, then (2,3)x16, then 4x64. done pulses once; ready=1 in the following cycle.
- req with cost=3, then cost=32-masked 0 -> cost_err pulses each time. No phase_go; ready stays 1; rounds_left=0.
- cost=5 job; inject phase_done coincident with a phase_go and during IDLE -> ignored. Total go count still 1+64+64=129.
- cost=31 job; abort during 3rd EXP_SALT WAIT while phase_done=1 -> IDLE next cycle. rounds_left=0, no done. A new cost=4 req completes normally.
- Repeated req pulses while busy (cost=6 job) -> no effect. rounds_left trace 64..0 is monotonic, decrementing only on EXP_SALT completions.
- rst_l low mid-ENC (enc_left=30) -> outputs immediately at reset values, asynchronously. After release, behaviour is identical to the first scenario.
